writeback_trace_port: RTL and testbench

//  Parametrised successor to the core's fixed s1-s9 result reporter. Snoops the

---
 rtl/writeback_trace_port.sv | 117 +++++++++++
 tb/tb_writeback_trace_port.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/writeback_trace_port.sv
// Writeback trace port: snoops result writes to masked registers and queues them
// in a first-word-fall-through FIFO that drains to the peripheral on valid/ready.
module writeback_trace_port #(
    parameter int          CORE        = 0,
    parameter int          DATA_WIDTH  = 32,
    parameter logic [31:0] REG_MASK    = 32'h03FC0200,
    parameter int          FIFO_DEPTH  = 8,
    parameter int          DROP_BITS   = 16,
    parameter logic [1:0]  CHANNEL     = 2'b00,
    parameter bit          EN_AT_RESET = 1'b1,
    localparam int         PTR_W       = $clog2(FIFO_DEPTH),
    localparam int         CNT_W       = PTR_W + 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  write,
    input  logic [4:0]            write_reg,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [1:0]            from_peripheral,
    input  logic                  from_peripheral_valid,
    output logic [1:0]            to_peripheral,
    output logic [4:0]            to_peripheral_reg,
    output logic [DATA_WIDTH-1:0] to_peripheral_data,
    output logic                  to_peripheral_valid,
    input  logic                  to_peripheral_ready,
    output logic [DROP_BITS-1:0]  drop_count,
    output logic [CNT_W-1:0]      fifo_count,
    input  logic                  report
);

    typedef struct packed {
        logic [4:0]            rd;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    typedef enum logic [1:0] {
        CMD_NOP     = 2'b00,
        CMD_ENABLE  = 2'b01,
        CMD_DISABLE = 2'b10,
        CMD_FLUSH   = 2'b11
    } cmd_e;

    entry_t           mem [FIFO_DEPTH];
    entry_t           head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             enable;

    logic hit, full, push, pop, drop, flush;
    cmd_e cmd;

    assign cmd   = cmd_e'(from_peripheral);
    assign flush = from_peripheral_valid && (cmd == CMD_FLUSH);

    // x0 is hardwired zero, so a write to it is never architecturally visible.
    assign hit  = write && (write_reg != 5'd0) && REG_MASK[write_reg] && enable;
    assign full = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign to_peripheral_valid = (fifo_count != '0);
    assign pop  = to_peripheral_valid && to_peripheral_ready;
    assign push = hit && (!full || pop);
    assign drop = hit && full && !pop;

    // Gate the head with valid so idle outputs read zero rather than stale storage.
    assign head               = mem[rd_ptr];
    assign to_peripheral      = to_peripheral_valid ? CHANNEL   : 2'b00;
    assign to_peripheral_reg  = to_peripheral_valid ? head.rd   : 5'd0;
    assign to_peripheral_data = to_peripheral_valid ? head.data : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            drop_count <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            drop_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
            if (drop && (drop_count != '1))
                drop_count <= drop_count + DROP_BITS'(1);
        end
    end

    // Storage needs no reset: fifo_count decides what is live.
    always_ff @(posedge clock) begin
        if (!reset && !flush && push)
            mem[wr_ptr] <= '{rd: write_reg, data: write_data};
    end

    // Enable only changes on explicit commands; flush leaves it alone.
    always_ff @(posedge clock) begin
        if (reset)
            enable <= EN_AT_RESET;
        else if (from_peripheral_valid && (cmd == CMD_ENABLE))
            enable <= 1'b1;
        else if (from_peripheral_valid && (cmd == CMD_DISABLE))
            enable <= 1'b0;
    end

`ifndef SYNTHESIS
    always_ff @(posedge clock) begin
        if (report)
            $display("core %0d trace: drop_count=%0d fifo_count=%0d",
                     CORE, drop_count, fifo_count);
    end

    occupancy_bound: assert property (@(posedge clock) fifo_count <= CNT_W'(FIFO_DEPTH));
`endif

endmodule

// File: tb/tb_writeback_trace_port.sv
// Directed bench for writeback_trace_port: hand-computed expectations per step.
module tb_writeback_trace_port;

    localparam int DW = 32;
    localparam int DB = 3;

    logic          clock = 1'b0;
    logic          reset;
    logic          write;
    logic [4:0]    write_reg;
    logic [DW-1:0] write_data;
    logic [1:0]    from_peripheral;
    logic          from_peripheral_valid;
    logic [1:0]    to_peripheral;
    logic [4:0]    to_peripheral_reg;
    logic [DW-1:0] to_peripheral_data;
    logic          to_peripheral_valid;
    logic          to_peripheral_ready;
    logic [DB-1:0] drop_count;
    logic [3:0]    fifo_count;
    logic          report;

    int n_cmp = 0;
    int n_bad = 0;

    writeback_trace_port #(
        .CORE(3), .DATA_WIDTH(DW), .REG_MASK(32'h03FC0201), .FIFO_DEPTH(8),
        .DROP_BITS(DB), .CHANNEL(2'b10), .EN_AT_RESET(1'b1)
    ) dut (
        .clock(clock), .reset(reset), .write(write), .write_reg(write_reg),
        .write_data(write_data), .from_peripheral(from_peripheral),
        .from_peripheral_valid(from_peripheral_valid), .to_peripheral(to_peripheral),
        .to_peripheral_reg(to_peripheral_reg), .to_peripheral_data(to_peripheral_data),
        .to_peripheral_valid(to_peripheral_valid), .to_peripheral_ready(to_peripheral_ready),
        .drop_count(drop_count), .fifo_count(fifo_count), .report(report)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [4:0] r, input logic [DW-1:0] d);
        write = 1'b1; write_reg = r; write_data = d;
        tick();
        write = 1'b0;
    endtask

    task automatic cmd(input logic [1:0] c);
        from_peripheral = c; from_peripheral_valid = 1'b1;
    endtask

    initial begin
        logic [DW-1:0] exp_q [$];
        reset = 1'b1; write = 1'b0; write_reg = '0; write_data = '0;
        from_peripheral = 2'b00; from_peripheral_valid = 1'b0;
        to_peripheral_ready = 1'b0; report = 1'b0;
        tick(); tick();
        chk("rst_valid", to_peripheral_valid, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_drop",  drop_count, 0);
        chk("rst_tag",   to_peripheral, 0);
        chk("rst_reg",   to_peripheral_reg, 0);
        chk("rst_data",  to_peripheral_data, 0);
        reset = 1'b0;

        // 1: single hit, one-cycle latency, then pop
        wr(5'd18, 32'd5);
        chk("t1_valid", to_peripheral_valid, 1);
        chk("t1_reg",   to_peripheral_reg, 18);
        chk("t1_data",  to_peripheral_data, 5);
        chk("t1_tag",   to_peripheral, 2'b10);
        chk("t1_count", fifo_count, 1);
        to_peripheral_ready = 1'b1;
        tick();
        chk("t1_popped", fifo_count, 0);
        chk("t1_idle",   to_peripheral_valid, 0);
        to_peripheral_ready = 1'b0;

        // 2: unmasked register and x0 (mask bit 0 set) are ignored
        wr(5'd10, 32'd7);
        chk("t2_x10", fifo_count, 0);
        wr(5'd0, 32'd7);
        chk("t2_x0_count", fifo_count, 0);
        chk("t2_x0_valid", to_peripheral_valid, 0);

        // 3: overfill with ready low
        for (int i = 1; i <= 10; i++) wr(5'd9, DW'(i));
        chk("t3_count", fifo_count, 8);
        chk("t3_drop",  drop_count, 2);
        chk("t3_head",  to_peripheral_data, 1);

        // 4: full FIFO with simultaneous push and pop
        to_peripheral_ready = 1'b1;
        wr(5'd20, 32'd99);
        chk("t4_count", fifo_count, 8);
        chk("t4_drop",  drop_count, 2);
        for (int i = 2; i <= 8; i++) exp_q.push_back(DW'(i));
        exp_q.push_back(32'd99);
        foreach (exp_q[k]) begin
            chk("t4_valid", to_peripheral_valid, 1);
            chk("t4_order", to_peripheral_data, exp_q[k]);
            if (k == 7) chk("t4_last_reg", to_peripheral_reg, 20);
            tick();
        end
        chk("t4_empty", fifo_count, 0);
        to_peripheral_ready = 1'b0;

        // 5: enable/disable take effect the cycle after the command
        cmd(2'b10); wr(5'd19, 32'd44);
        from_peripheral_valid = 1'b0;
        chk("t5_old_en", fifo_count, 1);
        wr(5'd19, 32'd45);
        chk("t5_disabled", fifo_count, 1);
        cmd(2'b01); wr(5'd19, 32'd46);
        from_peripheral_valid = 1'b0;
        chk("t5_old_dis", fifo_count, 1);
        wr(5'd19, 32'd47);
        chk("t5_enabled", fifo_count, 2);
        chk("t5_head",    to_peripheral_data, 44);

        // 6: flush, saturating drops, flush racing a hit, reset mid-drain
        cmd(2'b11); tick(); from_peripheral_valid = 1'b0;
        chk("t6_flush_count", fifo_count, 0);
        chk("t6_flush_drop",  drop_count, 0);
        for (int i = 0; i < 17; i++) wr(5'd9, DW'(i));
        chk("t6_full", fifo_count, 8);
        chk("t6_sat",  drop_count, 7);
        to_peripheral_ready = 1'b1;
        cmd(2'b11); wr(5'd9, 32'hAA);
        from_peripheral_valid = 1'b0; to_peripheral_ready = 1'b0;
        chk("t6_fl_count", fifo_count, 0);
        chk("t6_fl_drop",  drop_count, 0);
        chk("t6_fl_valid", to_peripheral_valid, 0);
        chk("t6_fl_data",  to_peripheral_data, 0);
        wr(5'd21, 32'd5);
        chk("t6_en_kept", fifo_count, 1);
        chk("t6_reg",     to_peripheral_reg, 21);
        wr(5'd21, 32'd6); wr(5'd21, 32'd7);
        to_peripheral_ready = 1'b1;
        tick();
        chk("t6_drain", fifo_count, 2);
        to_peripheral_ready = 1'b0;
        cmd(2'b10); tick(); from_peripheral_valid = 1'b0;
        report = 1'b1;
        reset = 1'b1; to_peripheral_ready = 1'b1;
        wr(5'd21, 32'd8);
        report = 1'b0; reset = 1'b0; to_peripheral_ready = 1'b0;
        chk("t6_rst_count", fifo_count, 0);
        chk("t6_rst_valid", to_peripheral_valid, 0);
        wr(5'd9, 32'd9);
        chk("t6_rst_enable", fifo_count, 1);
        chk("t6_rst_data",   to_peripheral_data, 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
